// File: rtl/hpdcache_sram_ecc_scrubber.sv
// Background SECDED scrubber for a 1RW SRAM: reads every entry, writes back
// correctable words through the arbiter, and flags/counts error entries.
module hpdcache_sram_ecc_scrubber #(
  parameter int unsigned ADDR_SIZE  = 6,
  parameter int unsigned DATA_SIZE  = 32,
  parameter int unsigned DEPTH      = 2**ADDR_SIZE,
  parameter int unsigned NDATA      = 1,
  parameter int unsigned INTERVAL_W = 16,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         scrub_en_i,
  input  logic [INTERVAL_W-1:0]        interval_i,
  output logic                         sram_req_o,
  input  logic                         sram_gnt_i,
  output logic                         sram_we_o,
  output logic [ADDR_SIZE-1:0]         sram_addr_o,
  output logic [NDATA*DATA_SIZE-1:0]   sram_wdata_o,
  output logic [NDATA*DATA_SIZE-1:0]   sram_wmask_o,
  input  logic [NDATA*DATA_SIZE-1:0]   sram_rdata_i,
  input  logic [NDATA-1:0]             err_cor_i,
  input  logic [NDATA-1:0]             err_unc_i,
  input  logic                         snoop_we_i,
  input  logic [ADDR_SIZE-1:0]         snoop_addr_i,
  output logic                         cor_evt_o,
  output logic                         unc_evt_o,
  output logic [ADDR_SIZE-1:0]         evt_addr_o,
  output logic [CNT_W-1:0]             cor_cnt_o,
  output logic [CNT_W-1:0]             unc_cnt_o,
  output logic                         pass_done_o
);

  localparam int unsigned WIDTH = NDATA * DATA_SIZE;

  typedef enum logic [1:0] {IDLE, RD_REQ, RD_CHK, WR_REQ} state_t;

  state_t                  state;
  state_t                  state_next;

  logic [ADDR_SIZE-1:0]    ptr;
  logic [ADDR_SIZE-1:0]    ptr_next;
  logic [INTERVAL_W-1:0]   idle_cnt;
  logic [INTERVAL_W-1:0]   idle_cnt_next;
  logic                    abort_q;
  logic                    abort_next;

  logic                    req_next;
  logic                    we_next;
  logic [WIDTH-1:0]        wdata_next;
  logic [WIDTH-1:0]        wmask_next;
  logic                    cor_evt_next;
  logic                    unc_evt_next;
  logic [ADDR_SIZE-1:0]    evt_addr_next;
  logic [CNT_W-1:0]        cor_cnt_next;
  logic [CNT_W-1:0]        unc_cnt_next;
  logic                    pass_next;
  logic                    advance;

  logic [NDATA-1:0]        fix;
  logic                    any_cor;
  logic                    any_unc;
  logic                    any_fix;
  logic                    snoop_hit;
  logic                    abort_now;
  logic                    last;

  // Read-response decode and snoop match against the entry being scrubbed.
  always_comb begin
    fix       = err_cor_i & ~err_unc_i;
    any_cor   = |err_cor_i;
    any_unc   = |err_unc_i;
    any_fix   = |fix;
    snoop_hit = snoop_we_i && (snoop_addr_i == ptr);
    abort_now = abort_q || snoop_hit;
    last      = (ptr == ADDR_SIZE'(DEPTH - 1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (scrub_en_i && (idle_cnt >= interval_i)) state_next = RD_REQ;
      end
      RD_REQ: begin
        // A grant in the same cycle as disable still completes the read.
        if (sram_gnt_i)       state_next = RD_CHK;
        else if (!scrub_en_i) state_next = IDLE;
      end
      RD_CHK: begin
        state_next = (any_fix && !abort_now) ? WR_REQ : IDLE;
      end
      WR_REQ: begin
        // Grant wins over a same-cycle snoop: the arbiter orders both writes.
        if (sram_gnt_i || snoop_hit) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    ptr_next      = ptr;
    idle_cnt_next = idle_cnt;
    abort_next    = 1'b0;
    req_next      = (state_next == RD_REQ) || (state_next == WR_REQ);
    we_next       = (state_next == WR_REQ);
    wdata_next    = sram_wdata_o;
    wmask_next    = sram_wmask_o;
    cor_evt_next  = 1'b0;
    unc_evt_next  = 1'b0;
    evt_addr_next = evt_addr_o;
    cor_cnt_next  = cor_cnt_o;
    unc_cnt_next  = unc_cnt_o;
    pass_next     = 1'b0;
    advance       = 1'b0;

    case (state)
      IDLE: begin
        if ((state_next == IDLE) && (idle_cnt != '1)) begin
          idle_cnt_next = idle_cnt + INTERVAL_W'(1);
        end
      end
      RD_REQ: begin
        abort_next = sram_gnt_i && snoop_hit;
      end
      RD_CHK: begin
        cor_evt_next = any_cor;
        unc_evt_next = any_unc;
        if (any_cor || any_unc) evt_addr_next = ptr;
        if (any_cor && (cor_cnt_o != '1)) cor_cnt_next = cor_cnt_o + CNT_W'(1);
        if (any_unc && (unc_cnt_o != '1)) unc_cnt_next = unc_cnt_o + CNT_W'(1);
        if (state_next == WR_REQ) begin
          wdata_next = sram_rdata_i;
          for (int unsigned i = 0; i < NDATA; i++) begin
            wmask_next[i*DATA_SIZE +: DATA_SIZE] = {DATA_SIZE{fix[i]}};
          end
        end else begin
          advance = 1'b1;
        end
      end
      WR_REQ: begin
        advance = (state_next == IDLE);
      end
      default: ;
    endcase

    if (advance) begin
      ptr_next      = last ? '0 : ptr + ADDR_SIZE'(1);
      idle_cnt_next = '0;
      pass_next     = last;
    end
  end

  // Datapath and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr          <= '0;
      idle_cnt     <= '0;
      abort_q      <= 1'b0;
      sram_req_o   <= 1'b0;
      sram_we_o    <= 1'b0;
      sram_wdata_o <= '0;
      sram_wmask_o <= '0;
      cor_evt_o    <= 1'b0;
      unc_evt_o    <= 1'b0;
      evt_addr_o   <= '0;
      cor_cnt_o    <= '0;
      unc_cnt_o    <= '0;
      pass_done_o  <= 1'b0;
    end else begin
      ptr          <= ptr_next;
      idle_cnt     <= idle_cnt_next;
      abort_q      <= abort_next;
      sram_req_o   <= req_next;
      sram_we_o    <= we_next;
      sram_wdata_o <= wdata_next;
      sram_wmask_o <= wmask_next;
      cor_evt_o    <= cor_evt_next;
      unc_evt_o    <= unc_evt_next;
      evt_addr_o   <= evt_addr_next;
      cor_cnt_o    <= cor_cnt_next;
      unc_cnt_o    <= unc_cnt_next;
      pass_done_o  <= pass_next;
    end
  end

  assign sram_addr_o = ptr;

endmodule

// File: tb/tb_hpdcache_sram_ecc_scrubber.sv
// Bench for hpdcache_sram_ecc_scrubber: the bench plays SRAM and arbiter and
// checks events, counters and write-backs against a scoreboard.
module tb_hpdcache_sram_ecc_scrubber;

  localparam int unsigned AW    = 4;
  localparam int unsigned DW    = 8;
  localparam int unsigned ND    = 2;
  localparam int unsigned IW    = 4;
  localparam int unsigned CW    = 2;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned W     = ND * DW;
  localparam int          CMAX  = 3;

  logic          clk;
  logic          rst;
  logic          scrub_en;
  logic [IW-1:0] interval;
  logic          sram_req;
  logic          sram_gnt;
  logic          sram_we;
  logic [AW-1:0] sram_addr;
  logic [W-1:0]  sram_wdata;
  logic [W-1:0]  sram_wmask;
  logic [W-1:0]  sram_rdata;
  logic [ND-1:0] err_cor;
  logic [ND-1:0] err_unc;
  logic          snoop_we;
  logic [AW-1:0] snoop_addr;
  logic          cor_evt;
  logic          unc_evt;
  logic [AW-1:0] evt_addr;
  logic [CW-1:0] cor_cnt;
  logic [CW-1:0] unc_cnt;
  logic          pass_done;

  hpdcache_sram_ecc_scrubber #(
    .ADDR_SIZE(AW), .DATA_SIZE(DW), .DEPTH(DEPTH), .NDATA(ND),
    .INTERVAL_W(IW), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst(rst), .scrub_en_i(scrub_en), .interval_i(interval),
    .sram_req_o(sram_req), .sram_gnt_i(sram_gnt), .sram_we_o(sram_we),
    .sram_addr_o(sram_addr), .sram_wdata_o(sram_wdata), .sram_wmask_o(sram_wmask),
    .sram_rdata_i(sram_rdata), .err_cor_i(err_cor), .err_unc_i(err_unc),
    .snoop_we_i(snoop_we), .snoop_addr_i(snoop_addr),
    .cor_evt_o(cor_evt), .unc_evt_o(unc_evt), .evt_addr_o(evt_addr),
    .cor_cnt_o(cor_cnt), .unc_cnt_o(unc_cnt), .pass_done_o(pass_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int            cyc;
    logic          cor;
    logic          unc;
    logic [AW-1:0] addr;
    int            ccnt;
    int            ucnt;
  } evt_t;

  typedef struct {
    logic [AW-1:0] addr;
    logic [W-1:0]  data;
    logic [W-1:0]  mask;
  } wr_t;

  evt_t evt_q[$];
  wr_t  wr_q[$];

  int n_tests;
  int n_fail;
  int cyc;

  logic [W-1:0]  mem     [DEPTH];
  logic [ND-1:0] cor_tab [DEPTH];
  logic [ND-1:0] unc_tab [DEPTH];
  // 0 none, 1 snoop at read grant, 2 snoop during check, 3 snoop while write held, 4 snoop other addr while held
  int            abort_mode [DEPTH];

  bit            rd_gnt_en;
  int            wr_hold;
  int            hold_cnt;
  bit            rd_pending;
  bit            rd_abort;
  logic [AW-1:0] rd_addr;
  logic [AW-1:0] exp_rd_addr;
  int            rd_grants;
  int            pass_cnt;
  int            last_rd_cyc;
  int            gap_exp;
  int            exp_cor;
  int            exp_unc;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [W-1:0] mask_of(input logic [ND-1:0] f);
    logic [W-1:0] m;
    for (int i = 0; i < int'(ND); i++) m[i*DW +: DW] = {DW{f[i]}};
    return m;
  endfunction

  // One clock: compare outputs at the falling edge, then drive the next inputs.
  task automatic cycle();
    evt_t          e;
    wr_t           w;
    logic [ND-1:0] f;
    bit            have_e;
    @(negedge clk);
    cyc++;
    snoop_we   = 1'b0;
    sram_gnt   = 1'b0;
    err_cor    = '0;
    err_unc    = '0;
    sram_rdata = '0;

    have_e = (evt_q.size() > 0) && (evt_q[0].cyc == cyc);
    if (have_e) e = evt_q.pop_front();
    else begin e.cor = 1'b0; e.unc = 1'b0; e.addr = '0; e.ccnt = 0; e.ucnt = 0; end
    if (e.cor || e.unc || cor_evt || unc_evt) begin
      check("cor_evt", 64'(cor_evt), 64'(e.cor));
      check("unc_evt", 64'(unc_evt), 64'(e.unc));
    end
    if (e.cor || e.unc) begin
      check("evt_addr", 64'(evt_addr), 64'(e.addr));
      check("cor_cnt", 64'(cor_cnt), 64'(e.ccnt));
      check("unc_cnt", 64'(unc_cnt), 64'(e.ucnt));
    end
    if (pass_done) pass_cnt++;

    if (rd_pending) begin
      rd_pending = 1'b0;
      sram_rdata = mem[rd_addr];
      err_cor    = cor_tab[rd_addr];
      err_unc    = unc_tab[rd_addr];
      if (abort_mode[rd_addr] == 2) begin
        snoop_we = 1'b1; snoop_addr = rd_addr; rd_abort = 1'b1;
      end
      if ((|cor_tab[rd_addr]) && exp_cor < CMAX) exp_cor++;
      if ((|unc_tab[rd_addr]) && exp_unc < CMAX) exp_unc++;
      evt_q.push_back('{cyc + 1, |cor_tab[rd_addr], |unc_tab[rd_addr], rd_addr, exp_cor, exp_unc});
      f = cor_tab[rd_addr] & ~unc_tab[rd_addr];
      if ((|f) && !rd_abort) wr_q.push_back('{rd_addr, mem[rd_addr], mask_of(f)});
      rd_abort = 1'b0;
    end

    if (!(sram_req && sram_we)) hold_cnt = 0;
    if (sram_req && !sram_we && rd_gnt_en) begin
      check("rd_addr", 64'(sram_addr), 64'(exp_rd_addr));
      if (gap_exp >= 0 && last_rd_cyc >= 0) check("rd_gap", 64'(cyc - last_rd_cyc), 64'(gap_exp));
      last_rd_cyc = cyc;
      exp_rd_addr = AW'(exp_rd_addr + 1'b1);
      rd_grants++;
      sram_gnt   = 1'b1;
      rd_pending = 1'b1;
      rd_addr    = sram_addr;
      if (abort_mode[sram_addr] == 1) begin
        snoop_we = 1'b1; snoop_addr = sram_addr; rd_abort = 1'b1;
      end
    end else if (sram_req && sram_we) begin
      if (hold_cnt < wr_hold) begin
        hold_cnt++;
        if (abort_mode[sram_addr] == 3) begin
          snoop_we = 1'b1; snoop_addr = sram_addr;
          if (wr_q.size() > 0) void'(wr_q.pop_front());
          else check("abort_without_write", 64'(1), 64'(0));
        end else if (abort_mode[sram_addr] == 4) begin
          snoop_we = 1'b1; snoop_addr = sram_addr ^ AW'(1);
        end
      end else begin
        hold_cnt = 0;
        sram_gnt = 1'b1;
        if (wr_q.size() == 0) begin
          check("unexpected_write", 64'(sram_addr), 64'('1));
        end else begin
          w = wr_q.pop_front();
          check("wr_addr", 64'(sram_addr), 64'(w.addr));
          check("wr_data", 64'(sram_wdata), 64'(w.data));
          check("wr_mask", 64'(sram_wmask), 64'(w.mask));
        end
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; scrub_en = 1'b0; interval = '0; sram_gnt = 1'b0;
    sram_rdata = '0; err_cor = '0; err_unc = '0; snoop_we = 1'b0; snoop_addr = '0;
    evt_q.delete(); wr_q.delete();
    rd_gnt_en = 1'b1; wr_hold = 0; hold_cnt = 0; rd_pending = 1'b0; rd_abort = 1'b0;
    rd_addr = '0; exp_rd_addr = '0; rd_grants = 0; pass_cnt = 0;
    last_rd_cyc = -1; gap_exp = -1; exp_cor = 0; exp_unc = 0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      mem[i] = W'($urandom); cor_tab[i] = '0; unc_tab[i] = '0; abort_mode[i] = 0;
    end
    repeat (2) @(negedge clk);
    check("reset_outputs", 64'({sram_req, sram_we, sram_addr, sram_wdata, sram_wmask,
          cor_evt, unc_evt, evt_addr, cor_cnt, unc_cnt, pass_done}), 64'(0));
    rst = 1'b0;
  endtask

  task automatic run_reads(input int n, input int budget);
    int target;
    int k;
    target = rd_grants + n;
    k = 0;
    while (rd_grants < target && k < budget) begin
      cycle();
      k++;
    end
    if (rd_grants < target) check("read_timeout", 64'(rd_grants), 64'(target));
  endtask

  task automatic end_scenario(input int exp_pass);
    scrub_en = 1'b0;
    repeat (10) cycle();
    check("evt_q_drained", 64'(evt_q.size()), 64'(0));
    check("wr_q_drained", 64'(wr_q.size()), 64'(0));
    check("pass_cnt", 64'(pass_cnt), 64'(exp_pass));
  endtask

  initial begin
    n_tests = 0; n_fail = 0; cyc = 0;

    // Clean full pass, back-to-back, then with an idle interval.
    do_reset();
    scrub_en = 1'b1; gap_exp = 3;
    run_reads(DEPTH + 1, 400);
    end_scenario(1);
    interval = IW'(3); gap_exp = 6; last_rd_cyc = -1; scrub_en = 1'b1;
    run_reads(3, 100);
    end_scenario(1);

    // Single correctable word.
    do_reset();
    cor_tab[2] = 2'b01;
    scrub_en = 1'b1;
    run_reads(4, 100);
    end_scenario(0);

    // Correctable and uncorrectable words in the same entry.
    do_reset();
    cor_tab[5] = 2'b11; unc_tab[5] = 2'b10;
    scrub_en = 1'b1;
    run_reads(7, 150);
    end_scenario(0);

    // Aborts in each window, a non-matching snoop, counter saturation.
    do_reset();
    wr_hold = 2;
    cor_tab[7]  = 2'b01; abort_mode[7]  = 3;
    cor_tab[9]  = 2'b10; abort_mode[9]  = 1;
    cor_tab[10] = 2'b01; abort_mode[10] = 2;
    cor_tab[12] = 2'b11; abort_mode[12] = 4;
    cor_tab[13] = 2'b10;
    scrub_en = 1'b1;
    run_reads(15, 300);
    end_scenario(0);

    // Read request held without grant, then cancelled by disable.
    do_reset();
    rd_gnt_en = 1'b0; scrub_en = 1'b1;
    for (int k = 0; k < 10 && !sram_req; k++) cycle();
    for (int k = 0; k < 10; k++) begin
      check("hold_req", 64'(sram_req), 64'(1));
      check("hold_we", 64'(sram_we), 64'(0));
      check("hold_addr", 64'(sram_addr), 64'(0));
      cycle();
    end
    scrub_en = 1'b0;
    cycle();
    check("req_dropped", 64'(sram_req), 64'(0));
    cycle();
    check("req_stays_low", 64'(sram_req), 64'(0));
    scrub_en = 1'b1; rd_gnt_en = 1'b1;
    run_reads(2, 50);
    end_scenario(0);

    // Saturating counter over five correctable entries.
    do_reset();
    for (int i = 0; i < 5; i++) cor_tab[i] = 2'b01;
    scrub_en = 1'b1;
    run_reads(6, 200);
    end_scenario(0);

    // Reset asserted while a write-back waits for grant.
    do_reset();
    cor_tab[1] = 2'b10; wr_hold = 5;
    scrub_en = 1'b1;
    for (int k = 0; k < 60 && !(sram_req && sram_we); k++) cycle();
    check("wr_req_reached", 64'(sram_req && sram_we), 64'(1));
    rst = 1'b1;
    #1;
    check("async_reset_outputs", 64'({sram_req, sram_we, sram_addr, sram_wdata, sram_wmask,
          cor_evt, unc_evt, evt_addr, cor_cnt, unc_cnt, pass_done}), 64'(0));
    do_reset();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
